// File: rtl/imem_dmem_arbiter.sv
// Arbiter for one single-ported, fixed-latency SRAM that is shared by instruction fetch and load/store.
// MEM normally wins. An owed flag limits MEM to one access between fetches. A fetch made stale by a branch completes but is dropped.
module imem_dmem_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    input  logic          branch_taken,
    output logic [31:0]   if_rdata,
    output logic          if_valid,
    output logic          freeze_if,
    input  logic          mem_rd_en,
    input  logic          mem_wr_en,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    output logic [31:0]   mem_rdata,
    output logic          mem_ready,
    output logic          freeze_mem,
    output logic          sram_en,
    output logic          sram_we,
    output logic [AW-3:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    // state    | meaning
    // IDLE     | no access in flight; grant decision made this cycle
    // IF_BUSY  | fetch occupying the SRAM for LAT cycles
    // MEM_BUSY | load/store occupying the SRAM for LAT cycles
    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            if_owed, discard;
    logic            we_q;
    logic [AW-3:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            mem_req, grant_if, grant_mem, done, busy;
    logic            unused_addr_bits;

    assign mem_req = mem_rd_en | mem_wr_en;
    assign busy    = (state != IDLE);
    assign unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0]};

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // A fetch that is owed a turn keeps priority even while a branch blocks it.
                if (if_owed && if_req) begin
                    grant_if = ~branch_taken;
                end else if (mem_req) begin
                    grant_mem = 1'b1;
                end else if (if_req && !branch_taken) begin
                    grant_if = 1'b1;
                end
                if (grant_if)
                    state_nxt = IF_BUSY;
                else if (grant_mem)
                    state_nxt = MEM_BUSY;
            end
            IF_BUSY, MEM_BUSY: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            if_owed   <= 1'b0;
            discard   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            mem_rdata <= '0;
            mem_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            if_valid  <= 1'b0;
            mem_ready <= 1'b0;

            if (grant_if || grant_mem)
                cnt <= CW'(LAT - 1);
            else if (busy && cnt != '0)
                cnt <= cnt - 1'b1;

            if (grant_if) begin
                addr_q  <= if_addr[AW-1:2];
                we_q    <= 1'b0;
                wdata_q <= '0;
                if_owed <= 1'b0;
                discard <= 1'b0;
            end
            if (grant_mem) begin
                addr_q  <= mem_addr[AW-1:2];
                we_q    <= mem_wr_en;
                wdata_q <= mem_wdata;
                if (if_req)
                    if_owed <= 1'b1;
            end

            // A branch in the final busy cycle also makes the fetch stale.
            if (state == IF_BUSY) begin
                if (done) begin
                    if (!(discard || branch_taken)) begin
                        if_rdata <= sram_rdata;
                        if_valid <= 1'b1;
                    end
                    discard <= 1'b0;
                end else if (branch_taken) begin
                    discard <= 1'b1;
                end
            end

            if (state == MEM_BUSY && done) begin
                if (!we_q)
                    mem_rdata <= sram_rdata;
                mem_ready <= 1'b1;
            end
        end
    end

    assign sram_en    = busy;
    assign sram_we    = busy & we_q;
    assign sram_addr  = busy ? addr_q : '0;
    assign sram_wdata = busy ? wdata_q : '0;

    assign freeze_if  = if_req & ~if_valid;
    assign freeze_mem = mem_req & ~mem_ready;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: runs LAT=2 and LAT=1 instances through directed scenarios, then random traffic.
// Each cycle is compared against a transaction-level reference model.
module tb_imem_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_init(input logic [5:0] i);
        logic [31:0] v;
        v = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        return (i == 6'd0) ? 32'h0022_0000 : v;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int LAT = 2 - g;

        logic        rst, if_req, branch_taken, if_valid, freeze_if;
        logic        mem_rd_en, mem_wr_en, mem_ready, freeze_mem, sram_en, sram_we;
        logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
        logic [31:0] sram_wdata, sram_rdata;
        logic [29:0] sram_addr;
        bit   [31:0] sram_mem [64];
        bit          written  [64];
        bit          done;

        // reference model: one outstanding access with a count of remaining busy cycles
        int          m_left;
        bit          m_is_if, m_we, m_disc, m_owed, m_ifv, m_memr;
        logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;
        logic [31:0] gold [64];

        imem_dmem_arbiter #(.LAT(LAT), .AW(32)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .branch_taken(branch_taken),
            .if_rdata(if_rdata), .if_valid(if_valid), .freeze_if(freeze_if),
            .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
            .freeze_mem(freeze_mem),
            .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
            .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
        );

        assign sram_rdata = written[sram_addr[5:0]] ? sram_mem[sram_addr[5:0]]
                                                     : mem_init(sram_addr[5:0]);
        always @(posedge clk) begin
            if (sram_en && sram_we) begin
                sram_mem[sram_addr[5:0]] <= sram_wdata;
                written[sram_addr[5:0]]  <= 1'b1;
            end
        end

        task automatic grant_fetch();
            m_is_if = 1'b1; m_we = 1'b0; m_addr = if_addr; m_wdata = '0;
            m_left = LAT; m_owed = 1'b0; m_disc = 1'b0;
        endtask

        task automatic model_step();
            m_ifv  = 1'b0;
            m_memr = 1'b0;
            if (rst) begin
                m_left = 0; m_owed = 0; m_disc = 0; m_we = 0;
                m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_mem_rdata = '0;
                return;
            end
            if (m_left > 0) begin
                if (m_is_if && branch_taken) m_disc = 1'b1;
                if (m_left == 1) begin
                    if (m_is_if) begin
                        if (!m_disc) begin
                            m_if_rdata = gold[m_addr[7:2]];
                            m_ifv = 1'b1;
                        end
                        m_disc = 1'b0;
                    end else begin
                        if (m_we) gold[m_addr[7:2]] = m_wdata;
                        else      m_mem_rdata = gold[m_addr[7:2]];
                        m_memr = 1'b1;
                    end
                end
                m_left--;
            end else if (m_owed && if_req) begin
                if (!branch_taken) grant_fetch();
            end else if (mem_rd_en || mem_wr_en) begin
                m_is_if = 1'b0; m_we = mem_wr_en; m_addr = mem_addr; m_wdata = mem_wdata;
                m_left = LAT;
                if (if_req) m_owed = 1'b1;
            end else if (if_req && !branch_taken) begin
                grant_fetch();
            end
        endtask

        task automatic tick();
            bit busy;
            #1;
            chk("freeze_if",  freeze_if,  if_req & ~m_ifv);
            chk("freeze_mem", freeze_mem, (mem_rd_en | mem_wr_en) & ~m_memr);
            model_step();
            @(posedge clk);
            #1;
            busy = (m_left > 0);
            chk("if_valid",   if_valid,   m_ifv);
            chk("mem_ready",  mem_ready,  m_memr);
            chk("if_rdata",   if_rdata,   m_if_rdata);
            chk("mem_rdata",  mem_rdata,  m_mem_rdata);
            chk("sram_en",    sram_en,    busy);
            chk("sram_we",    sram_we,    busy & m_we);
            chk("sram_addr",  sram_addr,  busy ? m_addr[31:2] : 30'd0);
            chk("sram_wdata", sram_wdata, busy ? m_wdata : 32'd0);
        endtask

        initial begin
            logic [31:0] prev;
            int k;
            for (int i = 0; i < 64; i++) gold[i] = mem_init(6'(i));
            m_left = 0; m_owed = 0; m_disc = 0; m_is_if = 0; m_we = 0;
            m_ifv = 0; m_memr = 0; m_addr = '0; m_wdata = '0;
            m_if_rdata = '0; m_mem_rdata = '0;
            rst = 1'b1; if_req = 0; if_addr = '0; branch_taken = 0;
            mem_rd_en = 0; mem_wr_en = 0; mem_addr = '0; mem_wdata = '0;
            tick(); tick();
            chk("rst if_valid", if_valid, 0);
            chk("rst sram_en",  sram_en,  0);
            chk("rst if_rdata", if_rdata, 0);
            rst = 1'b0;
            tick();

            // single fetch of word 0
            if_req = 1; if_addr = 32'h0;
            repeat (LAT + 1) tick();
            chk("fetch0 valid", if_valid, 1);
            chk("fetch0 data",  if_rdata, 32'h0022_0000);
            if_req = 0;
            tick();

            // simultaneous requests: MEM first, owed fetch next, then second load
            if_req = 1; if_addr = 32'h8; mem_rd_en = 1; mem_addr = 32'h40;
            repeat (LAT + 1) tick();
            chk("owed mem_ready", mem_ready, 1);
            chk("owed if_valid0", if_valid, 0);
            mem_addr = 32'h44;
            repeat (LAT + 1) tick();
            chk("owed if_valid", if_valid, 1);
            chk("owed mem_wait", mem_ready, 0);
            if_req = 0;
            repeat (LAT + 1) tick();
            chk("2nd load ready", mem_ready, 1);
            chk("2nd load data",  mem_rdata, mem_init(6'h11));
            mem_rd_en = 0;
            tick();

            // store then load back
            mem_wr_en = 1; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
            tick();
            chk("store we",   sram_we,   1);
            chk("store addr", sram_addr, 30'd4);
            repeat (LAT) tick();
            chk("store ready", mem_ready, 1);
            mem_wr_en = 0; mem_rd_en = 1;
            repeat (LAT + 1) tick();
            chk("load back", mem_rdata, 32'hDEAD_BEEF);
            mem_rd_en = 0;
            tick();

            // flush of an in-flight fetch
            prev = m_if_rdata;
            if_req = 1; if_addr = 32'h20;
            tick();
            branch_taken = 1; if_addr = 32'h30;
            tick();
            branch_taken = 0;
            repeat (LAT - 1) tick();
            chk("flush no valid", if_valid, 0);
            chk("flush rdata",    if_rdata, prev);
            repeat (LAT + 1) tick();
            chk("redirect valid", if_valid, 1);
            chk("redirect data",  if_rdata, mem_init(6'd12));
            if_req = 0;
            tick();

            // reset during a load restarts it with full latency
            mem_rd_en = 1; mem_addr = 32'h4;
            tick();
            rst = 1;
            tick();
            rst = 0;
            chk("rst abort en",    sram_en,   0);
            chk("rst abort ready", mem_ready, 0);
            repeat (LAT + 1) tick();
            chk("restart ready", mem_ready, 1);
            chk("restart data",  mem_rdata, mem_init(6'd1));
            mem_rd_en = 0;
            tick();

            // back-to-back fetches at 0, 4, 8
            if_req = 1;
            for (int w = 0; w < 3; w++) begin
                if_addr = 32'(w) << 2;
                repeat (LAT + 1) tick();
                chk("b2b valid", if_valid, 1);
                chk("b2b data",  if_rdata, mem_init(6'(w)));
            end
            if_req = 0;
            tick();

            // random traffic
            for (int c = 0; c < 2000; c++) begin
                rst          = ($urandom_range(0, 249) == 0);
                branch_taken = ($urandom_range(0, 14) == 0);
                if (if_valid || !if_req) begin
                    if_req  = ($urandom_range(0, 2) != 0);
                    if_addr = rand_addr();
                end
                if (branch_taken) if_addr = rand_addr();
                if (mem_ready || !(mem_rd_en || mem_wr_en)) begin
                    if ($urandom_range(0, 2) == 0) begin
                        k = $urandom_range(1, 3);
                        mem_rd_en = k[0]; mem_wr_en = k[1];
                        mem_addr  = rand_addr();
                        mem_wdata = $urandom;
                    end else begin
                        mem_rd_en = 0; mem_wr_en = 0;
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    mem_rd_en = 0; mem_wr_en = 0;
                end
                tick();
            end
            rst = 0; if_req = 0; branch_taken = 0; mem_rd_en = 0; mem_wr_en = 0;
            repeat (LAT + 2) tick();
            done = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 40000 && !(cfg[0].done && cfg[1].done); c++) @(posedge clk);
        chk("bench done", {cfg[0].done, cfg[1].done}, 2'b11);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
